// File: rtl/z16_program_loader.sv
// z16_program_loader
//
// Serial boot loader for the Z16 instruction memory. It parses a byte-stream frame
//   SYNC, LEN_LO, LEN_HI, N x (lo, hi), CSUM
// and writes each 16-bit little-endian word to instruction memory. The first word goes to
// BASE_ADDR and each following word goes 2 bytes higher. The CPU is held in reset until a
// frame with a correct checksum has been loaded.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_rx_valid   byte available on i_rx_data
//   i_rx_data    received byte
//   o_rx_ready   byte accepted when i_rx_valid & o_rx_ready (1 once out of reset)
//   o_imem_wen   one-cycle instruction memory write strobe
//   o_imem_addr  byte address of the write
//   o_imem_wdata instruction word written (held between writes)
//   o_cpu_rst    CPU reset, low only once a verified program is loaded
//   o_done       program loaded and checksum verified
//   o_error      frame rejected (oversize length or bad checksum)

module z16_program_loader #(
    parameter int unsigned IMEM_WORDS = 256,
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [7:0]  SYNC_BYTE  = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_imem_wen,
    output logic [15:0] o_imem_addr,
    output logic [15:0] o_imem_wdata,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_error
);

    // The index must hold values up to IMEM_WORDS-1. One extra bit is kept so that the
    // post-increment after the last word cannot wrap.
    localparam int unsigned IdxW = $clog2(IMEM_WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDataLo,
        StDataHi,
        StCsum,
        StDone,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      lo_q, lo_d;
    logic            rx_ready_q;
    logic            wen_q, wen_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            cpu_rst_q, cpu_rst_d;

    logic            accept;
    logic [15:0]     len_word;
    logic [15:0]     word_off;

    assign accept   = i_rx_valid & rx_ready_q;
    // Full length once LEN_HI arrives; the low byte was parked in len_q[7:0].
    assign len_word = {i_rx_data, len_q[7:0]};
    assign word_off = 16'({idx_q, 1'b0});

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (accept) begin
            case (state_q)
                StIdle, StDone, StError: begin
                    if (i_rx_data == SYNC_BYTE) begin
                        state_d = StLenLo;
                        sum_d   = 8'h00;
                    end
                end
                StLenLo: begin
                    len_d   = {8'h00, i_rx_data};
                    sum_d   = sum_q + i_rx_data;
                    state_d = StLenHi;
                end
                StLenHi: begin
                    len_d = len_word;
                    sum_d = sum_q + i_rx_data;
                    if (32'(len_word) > IMEM_WORDS) begin
                        state_d = StError;
                    end else if (len_word == 16'h0000) begin
                        state_d = StCsum;
                    end else begin
                        idx_d   = '0;
                        state_d = StDataLo;
                    end
                end
                StDataLo: begin
                    lo_d    = i_rx_data;
                    sum_d   = sum_q + i_rx_data;
                    state_d = StDataHi;
                end
                StDataHi: begin
                    sum_d   = sum_q + i_rx_data;
                    wen_d   = 1'b1;
                    addr_d  = BASE_ADDR + word_off;
                    wdata_d = {i_rx_data, lo_q};
                    idx_d   = idx_q + 1'b1;
                    if (16'(idx_q) == len_q - 16'd1) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StDataLo;
                    end
                end
                StCsum: begin
                    if (i_rx_data == sum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StError;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Status flags follow the next state so that they appear one cycle after the byte.
        done_d    = (state_d == StDone);
        error_d   = (state_d == StError);
        cpu_rst_d = ~done_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            len_q      <= 16'h0000;
            sum_q      <= 8'h00;
            idx_q      <= '0;
            lo_q       <= 8'h00;
            rx_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 16'h0000;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            lo_q       <= lo_d;
            rx_ready_q <= 1'b1;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    assign o_rx_ready   = rx_ready_q;
    assign o_imem_wen   = wen_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_z16_program_loader.sv
// tb_z16_program_loader
//
// Randomized-gap bench for z16_program_loader. A frame-position reference model predicts
// memory writes and status. A negedge monitor compares every write strobe and the status
// flags on every cycle against that model.

module tb_z16_program_loader;

    localparam int unsigned IMEM_WORDS = 256;
    localparam logic [15:0] BASE_ADDR  = 16'h0000;
    localparam logic [7:0]  SYNC_BYTE  = 8'h5A;

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_wen;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    z16_program_loader #(
        .IMEM_WORDS(IMEM_WORDS),
        .BASE_ADDR (BASE_ADDR),
        .SYNC_BYTE (SYNC_BYTE)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .o_imem_wen  (imem_wen),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_cpu_rst   (cpu_rst),
        .o_done      (done),
        .o_error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the position of each byte in the current frame.
    bit          m_active;
    bit          m_done;
    bit          m_err;
    logic [7:0]  m_buf[$];
    logic [31:0] exp_wr[$];
    bit          chk_en;

    task automatic model_byte(input logic [7:0] b);
        int n;
        int nw;
        int k;
        logic [7:0] s;
        if (!m_active) begin
            if (b == SYNC_BYTE) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_err    = 1'b0;
                m_buf.delete();
            end
            return;
        end
        m_buf.push_back(b);
        n = m_buf.size();
        if (n < 2) return;
        nw = int'({m_buf[1], m_buf[0]});
        if (n == 2 && nw > int'(IMEM_WORDS)) begin
            m_active = 1'b0;
            m_err    = 1'b1;
            return;
        end
        if (n >= 4 && n <= 2 * nw + 2 && (n % 2) == 0) begin
            k = (n - 4) / 2;
            exp_wr.push_back({16'(int'(BASE_ADDR) + 2 * k), m_buf[n-1], m_buf[n-2]});
        end
        if (n == 2 * nw + 3) begin
            s = 8'h00;
            for (int i = 0; i < n - 1; i++) s = s + m_buf[i];
            m_active = 1'b0;
            if (s == b) m_done = 1'b1;
            else        m_err  = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (imem_wen) begin
                if (exp_wr.size() == 0) begin
                    check_eq("unexpected_wen", 32'(imem_wen), 32'd0);
                end else begin
                    check_eq("write", {imem_addr, imem_wdata}, exp_wr.pop_front());
                end
            end
            check_eq("done", 32'(done), 32'(m_done));
            check_eq("error", 32'(error), 32'(m_err));
            check_eq("cpu_rst", 32'(cpu_rst), 32'(!m_done));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) check_eq("ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        model_byte(b);
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send_byte(fr[i], $urandom_range(0, 5));
        go_idle(2);
    endtask

    task automatic make_frame(input int nw, input bit bad, output logic [7:0] fr[$]);
        logic [7:0] s;
        logic [7:0] b;
        fr.delete();
        fr.push_back(SYNC_BYTE);
        fr.push_back(8'(nw));
        fr.push_back(8'(nw >> 8));
        s = 8'(nw) + 8'(nw >> 8);
        for (int i = 0; i < 2 * nw; i++) begin
            b = 8'($urandom_range(0, 255));
            fr.push_back(b);
            s = s + b;
        end
        fr.push_back(bad ? s + 8'h01 : s);
    endtask

    task automatic end_checks(input string tag, input bit exp_done, input bit exp_err);
        check_eq({tag, "_pending"}, 32'(exp_wr.size()), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
        check_eq({tag, "_error"}, 32'(error), 32'(exp_err));
        check_eq({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr1[$];
        logic [7:0] fr[$];
        bit bad;

        fr1 = {8'h5A, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h16};
        chk_en   = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(rx_ready), 32'd0);
        check_eq("rst_wen", 32'(imem_wen), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check_eq("rst_wdata", 32'(imem_wdata), 32'd0);
        check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(rx_ready), 32'd1);
        chk_en = 1'b1;

        // Good two-word frame
        send_frame(fr1);
        end_checks("good", 1'b1, 1'b0);

        // Reload from DONE
        send_byte(SYNC_BYTE, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        check_eq("reload_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("reload_done", 32'(done), 32'd0);
        fr = {8'h01, 8'h00, 8'hCD, 8'hAB, 8'h79};
        send_frame(fr);
        end_checks("reload", 1'b1, 1'b0);

        // Bad checksum
        fr = fr1;
        fr[7] = 8'h17;
        send_frame(fr);
        end_checks("badcsum", 1'b0, 1'b1);

        // Oversize length, trailing bytes, then a good frame
        fr = {8'h5A, 8'h01, 8'h01, 8'h34, 8'h12};
        send_frame(fr);
        end_checks("oversize", 1'b0, 1'b1);
        send_frame(fr1);
        end_checks("after_oversize", 1'b1, 1'b0);

        // Noise followed by an empty frame
        fr = {8'h00, 8'hFF, 8'h12, 8'h5A, 8'h00, 8'h00, 8'h00};
        send_frame(fr);
        end_checks("empty", 1'b1, 1'b0);

        // Asynchronous reset after the first word
        fr = {8'h5A, 8'h02, 8'h00, 8'h34, 8'h12};
        foreach (fr[i]) send_byte(fr[i], $urandom_range(0, 5));
        go_idle(2);
        check_eq("midrst_pending", 32'(exp_wr.size()), 32'd0);
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_ready", 32'(rx_ready), 32'd0);
        check_eq("midrst_wen", 32'(imem_wen), 32'd0);
        check_eq("midrst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check_eq("midrst_wdata", 32'(imem_wdata), 32'd0);
        check_eq("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_eq("midrst_error", 32'(error), 32'd0);
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        send_frame(fr1);
        end_checks("after_rst", 1'b1, 1'b0);

        // Largest accepted length
        make_frame(int'(IMEM_WORDS), 1'b0, fr);
        send_frame(fr);
        end_checks("maxlen", 1'b1, 1'b0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            bad = ($urandom_range(0, 1) == 1);
            make_frame($urandom_range(0, 8), bad, fr);
            send_frame(fr);
            end_checks("random", !bad, bad);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z16_program_loader.md
Name: z16_program_loader

Overview:
- Serial boot loader sitting directly upstream of the Z16 CPU's instruction memory.
- Consumes a byte stream (UART receiver side), assembles 16-bit little-endian instruction words and writes them into instruction memory at byte addresses stepping by 2, matching the CPU's PC increment.
- Holds the CPU in reset until a complete, checksum-verified program has been loaded.

Parameters:
- IMEM_WORDS, 256: maximum number of words accepted; a larger length field is an error.
- BASE_ADDR, 16'h0000: byte address of the first word written.
- SYNC_BYTE, 8'h5A: frame start marker.

Ports:
- i_clk, input, 1: system clock, rising edge.
- i_rst, input, 1: asynchronous active-high reset.
- i_rx_valid, input, 1: byte available on i_rx_data.
- i_rx_data, input, 8: received byte.
- o_rx_ready, output, 1: loader accepts a byte; constant 1 out of reset. A byte is consumed on a cycle with i_rx_valid & o_rx_ready.
- o_imem_wen, output, 1: one-cycle instruction memory write strobe.
- o_imem_addr, output, 16: byte address of the write.
- o_imem_wdata, output, 16: instruction word to write.
- o_cpu_rst, output, 1: reset to the CPU; 1 except in DONE.
- o_done, output, 1: program loaded and verified.
- o_error, output, 1: frame rejected.

Behaviour:
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (16-bit word count N), then N words each sent low byte then high byte, then CSUM.
- CSUM is the 8-bit sum mod 256 of LEN_LO, LEN_HI and all data bytes. SYNC_BYTE is excluded.
- Reset values: o_rx_ready=0 while i_rst is high, then 1. o_imem_wen=0, o_imem_addr=BASE_ADDR, o_imem_wdata=0, o_cpu_rst=1, o_done=0, o_error=0. State is IDLE; word counter, length and running sum are all 0.
- Reset is asynchronous. Asserting i_rst mid-frame aborts immediately with no further writes. Words already written stay in memory.
- All outputs are registered. State advances only on accepted bytes, so any number of idle cycles between bytes is allowed.
- FSM transitions on an accepted byte:
  - IDLE: SYNC_BYTE -> LEN_LO and clear the sum; any other byte is discarded.
  - LEN_LO -> LEN_HI.
  - LEN_HI: if N > IMEM_WORDS -> ERROR; if N == 0 -> CSUM; otherwise -> DATA_LO with the word index cleared.
  - DATA_LO: latch the low byte -> DATA_HI.
  - DATA_HI: assemble {hi, lo} and issue the write; if this was word N-1 -> CSUM, else -> DATA_LO.
  - CSUM: if the byte equals the running sum -> DONE, else -> ERROR.
  - DONE / ERROR: SYNC_BYTE -> LEN_LO. The next cycle sets o_cpu_rst=1, o_done=0 and o_error=0. Other bytes are ignored.
- Write timing:
  - o_imem_wen pulses high for exactly one cycle, the cycle after the DATA_HI byte is accepted.
  - o_imem_addr = BASE_ADDR + 2*index, with 16-bit wrap-around.
  - o_imem_wdata is held until the next write.
- Status outputs:
  - o_done=1 and o_cpu_rst=0 from the cycle after the correct CSUM byte is accepted.
  - o_error=1 from the cycle after the failing byte is accepted; o_cpu_rst stays 1.
  - On a checksum failure, memory has already been written; the CPU stays held in reset.
- Within a frame, SYNC_BYTE has no special meaning and is treated as data or length.
- The running sum and word index use modular arithmetic. The index width is sufficient for IMEM_WORDS.

Test Plan:
1. Good two-word frame: send 5A 02 00 34 12 78 56 16.
   - Expect wen pulses: addr 0000 data 1234, then addr 0002 data 5678.
   - Expect o_done=1 and o_cpu_rst=0 after byte 16.
2. Bad checksum: same frame with CSUM 17.
   - Expect two writes, then o_error=1, o_cpu_rst=1, o_done=0.
3. Oversize length: send 5A 01 01 (N=257).
   - Expect o_error=1 after LEN_HI and no wen pulses.
   - Trailing bytes are ignored; a subsequent valid frame loads correctly.
4. Noise and empty frame: send 00 FF 12 5A 00 00 00 with random 0–5 cycle valid gaps.
   - Expect no writes and o_done=1.
5. Reset mid-frame: assert i_rst asynchronously (between clock edges) after the first word of frame 1.
   - Expect outputs at reset values immediately.
   - Resend full frame 1: writes restart at 0000, then o_done=1.
6. Reload from DONE: after scenario 1, send 5A.
   - Expect o_cpu_rst=1 and o_done=0 the next cycle.
   - Frame 5A 01 00 CD AB 79 writes addr 0000 data ABCD, then o_done=1.
